data_mem_ctrl: RTL

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_ctrl.sv
// Byte/halfword/word data memory with a one-cycle load pipeline and a power-up CLEAR sweep.
// Optional macro DATA_MEM_PRELOAD_EN makes CLEAR write PRELOAD_VAL into the low PRELOAD_WORDS words.
module data_mem_ctrl #(
    parameter int unsigned DEPTH         = 32,
    parameter int unsigned PRELOAD_WORDS = 5,
    parameter logic [31:0] PRELOAD_VAL   = 32'h0000_0003
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [1:0]  size_i,
    input  logic        sign_ext_i,
    input  logic [31:0] wdata_i,
    output logic        ready_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    localparam logic [0:0] StClear = 1'b0;
    localparam logic [0:0] StIdle  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rvalid_q, rvalid_d;
    logic          err_q, err_d;
    logic [31:0]   mem_q [DEPTH];

    logic          accept, legal, in_range, aligned;
    logic [AW-1:0] widx;
    logic [31:0]   rword, rshift, ldata, wshift, clr_val;
    logic [3:0]    be;

    // An access coinciding with reset is dropped entirely, including its store.
    assign accept   = req_i && (state_q == StIdle) && !reset_i;
    assign widx     = addr_i[AW+1:2];
    assign in_range = (addr_i[31:AW+2] == '0);
    assign legal    = aligned && in_range;
    assign rword    = mem_q[widx];
    assign rshift   = rword >> {addr_i[1:0], 3'b000};
    assign wshift   = wdata_i << {addr_i[1:0], 3'b000};

`ifdef DATA_MEM_PRELOAD_EN
    assign clr_val = (32'(clr_idx_q) < PRELOAD_WORDS) ? PRELOAD_VAL : '0;
`else
    assign clr_val = '0;
    logic unused_preload;
    assign unused_preload = ^{PRELOAD_VAL, PRELOAD_WORDS};
`endif

    always_comb begin
        aligned = 1'b0;
        be      = 4'b0000;
        ldata   = rword;
        case (size_i)
            2'b00: begin
                aligned = 1'b1;
                be      = 4'b0001 << addr_i[1:0];
                ldata   = {{24{sign_ext_i & rshift[7]}}, rshift[7:0]};
            end
            2'b01: begin
                aligned = !addr_i[0];
                be      = 4'b0011 << addr_i[1:0];
                ldata   = {{16{sign_ext_i & rshift[15]}}, rshift[15:0]};
            end
            2'b10: begin
                aligned = (addr_i[1:0] == 2'b00);
                be      = 4'b1111;
                ldata   = rword;
            end
            default: begin
                aligned = 1'b0;
                be      = 4'b0000;
                ldata   = rword;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rdata_d   = rdata_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        if (state_q == StClear) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d = StIdle;
            end
        end else if (accept) begin
            if (!legal) begin
                err_d = 1'b1;
            end else if (!we_i) begin
                rvalid_d = 1'b1;
                rdata_d  = ldata;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= StClear;
            clr_idx_q <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == StClear) begin
            mem_q[clr_idx_q] <= clr_val;
        end else if (accept && legal && we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end

    assign ready_o  = (state_q == StIdle);
    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;

endmodule
